// File: rtl/pms_axi_rd_id_remap.sv
// AXI read-channel ID remapper: folds wide input IDs onto a small table of in-flight IDs
// and restores the original ID on each R beat.
`timescale 1ns/1ps
module pms_axi_rd_id_remap #(
    parameter int unsigned AxiIdInpWidth = 7,
    parameter int unsigned AxiIdOupWidth = 6,
    parameter int unsigned AxiAddrWidth  = 32,
    parameter int unsigned AxiDataWidth  = 64,
    parameter int unsigned AxiUserWidth  = 6,
    parameter int unsigned MaxUniqIds    = 4,
    parameter int unsigned MaxTxnsPerId  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    // AR, slave side
    input  logic [AxiIdInpWidth-1:0] ar_id_i,
    input  logic [AxiAddrWidth-1:0]  ar_addr_i,
    input  logic [7:0]               ar_len_i,
    input  logic [2:0]               ar_size_i,
    input  logic [1:0]               ar_burst_i,
    input  logic [AxiUserWidth-1:0]  ar_user_i,
    input  logic                     ar_valid_i,
    output logic                     ar_ready_o,
    // AR, master side
    output logic [AxiIdOupWidth-1:0] ar_id_o,
    output logic [AxiAddrWidth-1:0]  ar_addr_o,
    output logic [7:0]               ar_len_o,
    output logic [2:0]               ar_size_o,
    output logic [1:0]               ar_burst_o,
    output logic [AxiUserWidth-1:0]  ar_user_o,
    output logic                     ar_valid_o,
    input  logic                     ar_ready_i,
    // R, master side
    input  logic [AxiIdOupWidth-1:0] r_id_i,
    input  logic [AxiDataWidth-1:0]  r_data_i,
    input  logic [1:0]               r_resp_i,
    input  logic                     r_last_i,
    input  logic [AxiUserWidth-1:0]  r_user_i,
    input  logic                     r_valid_i,
    output logic                     r_ready_o,
    // R, slave side
    output logic [AxiIdInpWidth-1:0] r_id_o,
    output logic [AxiDataWidth-1:0]  r_data_o,
    output logic [1:0]               r_resp_o,
    output logic                     r_last_o,
    output logic [AxiUserWidth-1:0]  r_user_o,
    output logic                     r_valid_o,
    input  logic                     r_ready_i,
    // status
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int unsigned IdxWidth = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;
    localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);

    typedef logic [IdxWidth-1:0] idx_t;
    typedef logic [CntWidth-1:0] cnt_t;

    logic [MaxUniqIds-1:0]    vld_q, vld_d;
    logic [AxiIdInpWidth-1:0] id_q  [MaxUniqIds];
    logic [AxiIdInpWidth-1:0] id_d  [MaxUniqIds];
    cnt_t                     cnt_q [MaxUniqIds];
    cnt_t                     cnt_d [MaxUniqIds];
    idx_t                     hold_q;
    logic                     hold_vld_q;
    logic                     err_q;

    logic match_found, free_found, dec_ok, decision_valid;
    idx_t match_idx, free_idx, sel;
    logic ar_hs;

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int unsigned k = 0; k < MaxUniqIds; k++) begin
            if (vld_q[k] && (id_q[k] == ar_id_i)) begin
                match_found = 1'b1;
                match_idx   = idx_t'(k);
            end
            if (!vld_q[k] && !free_found) begin
                free_found = 1'b1;
                free_idx   = idx_t'(k);
            end
        end
        sel    = '0;
        dec_ok = 1'b0;
        // A held decision wins so the output ID stays stable until the handshake.
        if (hold_vld_q) begin
            sel    = hold_q;
            dec_ok = 1'b1;
        end else if (match_found) begin
            sel    = match_idx;
            dec_ok = (cnt_q[match_idx] < cnt_t'(MaxTxnsPerId));
        end else begin
            sel    = free_idx;
            dec_ok = free_found;
        end
    end

    assign decision_valid = ar_valid_i & dec_ok;
    assign ar_valid_o     = decision_valid;
    assign ar_ready_o     = ar_ready_i & decision_valid;
    assign ar_hs          = ar_valid_o & ar_ready_i;
    assign ar_id_o        = AxiIdOupWidth'(sel);
    assign ar_addr_o      = ar_addr_i;
    assign ar_len_o       = ar_len_i;
    assign ar_size_o      = ar_size_i;
    assign ar_burst_o     = ar_burst_i;
    assign ar_user_o      = ar_user_i;

    logic r_in_range, r_ent_vld, r_hs, r_dec;
    idx_t r_idx;

    assign r_in_range = (32'(r_id_i) < MaxUniqIds);
    assign r_idx      = idx_t'(r_id_i);
    assign r_ent_vld  = r_in_range & vld_q[r_idx];
    assign r_hs       = r_valid_i & r_ready_i;
    assign r_dec      = r_hs & r_last_i & r_ent_vld;

    assign r_id_o    = r_ent_vld ? id_q[r_idx] : '0;
    assign r_data_o  = r_data_i;
    assign r_resp_o  = r_resp_i;
    assign r_last_o  = r_last_i;
    assign r_user_o  = r_user_i;
    assign r_valid_o = r_valid_i;
    assign r_ready_o = r_ready_i;

    assign busy_o = |vld_q;
    assign err_o  = err_q;

    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        cnt_d = cnt_q;
        for (int unsigned k = 0; k < MaxUniqIds; k++) begin
            if (ar_hs && (sel == idx_t'(k))) begin
                vld_d[k] = 1'b1;
                id_d[k]  = ar_id_i;
                // A same-cycle R-last on this entry cancels the increment.
                if (!(r_dec && (r_idx == idx_t'(k)))) begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end else if (r_dec && (r_idx == idx_t'(k))) begin
                cnt_d[k] = cnt_q[k] - 1'b1;
                if (cnt_q[k] == cnt_t'(1)) begin
                    vld_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            err_q      <= 1'b0;
            for (int unsigned k = 0; k < MaxUniqIds; k++) begin
                id_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
            cnt_q <= cnt_d;
            if (ar_hs) begin
                hold_vld_q <= 1'b0;
            end else if (ar_valid_o) begin
                hold_vld_q <= 1'b1;
                hold_q     <= sel;
            end
            if (r_hs && !r_ent_vld) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pms_axi_rd_id_remap.sv
// Directed and randomized bench for pms_axi_rd_id_remap against a table-level reference model.
`timescale 1ns/1ps
module tb_pms_axi_rd_id_remap;

    localparam int NE   = 4;
    localparam int MAXT = 8;

    logic        clk, rst;
    logic [6:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [5:0]  ar_user;
    logic        ar_valid, ar_ready;
    logic [5:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [5:0]  r_user;
    logic        r_valid, r_ready;

    logic        ar_ready_o, ar_valid_o;
    logic [5:0]  ar_id_o;
    logic [31:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic [1:0]  ar_burst_o;
    logic [5:0]  ar_user_o;
    logic        r_ready_o, r_valid_o;
    logic [6:0]  r_id_o;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;
    logic [5:0]  r_user_o;
    logic        busy_o, err_o;

    pms_axi_rd_id_remap dut (
        .clk_i(clk), .rst_i(rst),
        .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_size_i(ar_size),
        .ar_burst_i(ar_burst), .ar_user_i(ar_user), .ar_valid_i(ar_valid),
        .ar_ready_o(ar_ready_o),
        .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
        .ar_burst_o(ar_burst_o), .ar_user_o(ar_user_o), .ar_valid_o(ar_valid_o),
        .ar_ready_i(ar_ready),
        .r_id_i(r_id), .r_data_i(r_data), .r_resp_i(r_resp), .r_last_i(r_last),
        .r_user_i(r_user), .r_valid_i(r_valid), .r_ready_o(r_ready_o),
        .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .r_user_o(r_user_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready),
        .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: what each output ID currently stands for.
    bit         m_vld [NE];
    logic [6:0] m_id  [NE];
    int         m_cnt [NE];
    bit         m_hold_vld;
    int         m_hold;
    bit         m_err;
    bit         last_ar_hs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < NE; k++) begin
            m_vld[k] = 0; m_id[k] = '0; m_cnt[k] = 0;
        end
        m_hold_vld = 0; m_hold = 0; m_err = 0;
    endtask

    function automatic void m_decide(output bit dv, output int idx);
        int match;
        match = -1;
        dv = 0;
        idx = 0;
        if (!ar_valid) return;
        if (m_hold_vld) begin
            dv = 1; idx = m_hold; return;
        end
        for (int k = 0; k < NE; k++) if (m_vld[k] && m_id[k] == ar_id) match = k;
        if (match >= 0) begin
            idx = match; dv = (m_cnt[match] < MAXT); return;
        end
        for (int k = NE - 1; k >= 0; k--) if (!m_vld[k]) begin idx = k; dv = 1; end
    endfunction

    task automatic tick();
        bit dv, rv, ar_hs, r_hs, any;
        int idx, dec;
        @(negedge clk);
        m_decide(dv, idx);
        rv = 0;
        if (int'(r_id) < NE) rv = m_vld[r_id];
        any = 0;
        for (int k = 0; k < NE; k++) any |= m_vld[k];
        chk("ar_valid_o", 64'(ar_valid_o), 64'(dv));
        chk("ar_ready_o", 64'(ar_ready_o), 64'(dv & ar_ready));
        if (dv) chk("ar_id_o", 64'(ar_id_o), 64'(idx));
        chk("ar_addr_o", 64'(ar_addr_o), 64'(ar_addr));
        chk("ar_pass", 64'({ar_len_o, ar_size_o, ar_burst_o, ar_user_o}),
            64'({ar_len, ar_size, ar_burst, ar_user}));
        chk("r_id_o", 64'(r_id_o), rv ? 64'(m_id[r_id]) : 64'd0);
        chk("r_data_o", r_data_o, r_data);
        chk("r_pass", 64'({r_valid_o, r_ready_o, r_resp_o, r_last_o, r_user_o}),
            64'({r_valid, r_ready, r_resp, r_last, r_user}));
        chk("busy_o", 64'(busy_o), 64'(any));
        chk("err_o", 64'(err_o), 64'(m_err));

        ar_hs = dv && ar_ready;
        r_hs  = r_valid && r_ready;
        dec   = (r_hs && r_last && rv) ? int'(r_id) : -1;
        if (r_hs && !rv) m_err = 1;
        if (ar_hs) begin
            m_hold_vld = 0;
            m_vld[idx] = 1;
            m_id[idx]  = ar_id;
            if (dec != idx) m_cnt[idx]++;
        end else if (dv) begin
            m_hold_vld = 1;
            m_hold     = idx;
        end
        if (dec >= 0 && !(ar_hs && dec == idx)) begin
            m_cnt[dec]--;
            if (m_cnt[dec] == 0) m_vld[dec] = 0;
        end
        last_ar_hs = ar_hs;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input logic [6:0] id, input bit rdy);
        ar_valid = 1; ar_id = id; ar_addr = $urandom; ar_len = 8'd3; ar_size = 3'd3;
        ar_burst = 2'd1; ar_user = 6'($urandom); ar_ready = rdy;
    endtask

    task automatic set_r(input logic [5:0] id, input bit last);
        r_valid = 1; r_ready = 1; r_id = id; r_last = last; r_data = {$urandom, $urandom};
        r_resp = 2'($urandom); r_user = 6'($urandom);
    endtask

    task automatic idle();
        ar_valid = 0; ar_ready = 0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0;
        ar_burst = '0; ar_user = '0;
        r_valid = 0; r_ready = 0; r_id = '0; r_data = '0; r_resp = '0; r_last = 0; r_user = '0;
    endtask

    task automatic drain();
        ar_valid = 0;
        for (int k = 0; k < NE; k++) begin
            while (m_cnt[k] > 0) begin
                set_r(6'(k), 1);
                tick();
            end
        end
        r_valid = 0; r_last = 0;
    endtask

    initial begin
        idle();
        m_reset();
        last_ar_hs = 0;
        rst = 1;
        #2;
        chk("rst_ar_valid", 64'(ar_valid_o), 64'd0);
        chk("rst_ar_ready", 64'(ar_ready_o), 64'd0);
        chk("rst_r_valid", 64'(r_valid_o), 64'd0);
        chk("rst_r_ready", 64'(r_ready_o), 64'd0);
        chk("rst_ar_id", 64'(ar_id_o), 64'd0);
        chk("rst_r_id", 64'(r_id_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        #20 rst = 0;
        @(posedge clk);
        #1;

        // Single burst
        set_ar(7'h45, 1);
        #1 chk("single_ar_id", 64'(ar_id_o), 64'd0);
        tick();
        ar_valid = 0;
        for (int b = 0; b < 4; b++) begin
            set_r(6'd0, b == 3);
            #1 chk("single_r_id", 64'(r_id_o), 64'h45);
            tick();
        end
        r_valid = 0; r_last = 0;
        #1 chk("single_busy", 64'(busy_o), 64'd0);

        // Unique-ID exhaustion
        for (int i = 1; i <= 4; i++) begin
            set_ar(7'(i), 1);
            #1 chk("exh_ar_id", 64'(ar_id_o), 64'(i - 1));
            tick();
        end
        set_ar(7'h05, 1);
        #1 chk("exh_stall", 64'(ar_ready_o), 64'd0);
        tick();
        set_r(6'd2, 1);
        #1 chk("exh_stall_free", 64'(ar_ready_o), 64'd0);
        tick();
        r_valid = 0; r_last = 0;
        #1 chk("exh_reuse_rdy", 64'(ar_ready_o), 64'd1);
        chk("exh_reuse_id", 64'(ar_id_o), 64'd2);
        tick();
        drain();

        // Per-ID limit
        for (int i = 0; i < MAXT; i++) begin
            set_ar(7'h10, 1);
            tick();
        end
        set_ar(7'h10, 1);
        #1 chk("lim_stall", 64'(ar_ready_o), 64'd0);
        tick();
        set_r(6'd0, 1);
        tick();
        r_valid = 0; r_last = 0;
        #1 chk("lim_rel_rdy", 64'(ar_ready_o), 64'd1);
        chk("lim_rel_id", 64'(ar_id_o), 64'd0);
        tick();
        drain();

        // Hold stability
        set_ar(7'h20, 1); tick();
        set_ar(7'h21, 1); tick();
        set_ar(7'h22, 0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) set_r(6'd0, 1);
            else begin r_valid = 0; r_last = 0; end
            #1 chk("hold_id", 64'(ar_id_o), 64'd2);
            tick();
        end
        r_valid = 0; r_last = 0; ar_ready = 1;
        #1 chk("hold_hs_id", 64'(ar_id_o), 64'd2);
        tick();
        drain();

        // Same-cycle AR and R-last on an entry with cnt=1
        set_ar(7'h30, 1); tick();
        set_ar(7'h30, 1);
        set_r(6'd0, 1);
        tick();
        ar_valid = 0; r_valid = 0; r_last = 0;
        #1 chk("same_r_id", 64'(r_id_o), 64'h30);
        chk("same_busy", 64'(busy_o), 64'd1);
        set_ar(7'h30, 1);
        #1 chk("same_ar_id", 64'(ar_id_o), 64'd0);
        tick();
        drain();

        // Error on invalid entry, then asynchronous reset mid-burst
        set_r(6'd3, 1);
        tick();
        r_valid = 0; r_last = 0;
        #1 chk("err_set", 64'(err_o), 64'd1);
        repeat (3) tick();
        set_ar(7'h45, 1); tick();
        ar_valid = 0;
        set_r(6'd0, 0); tick();
        #2 rst = 1;
        #1 chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_err", 64'(err_o), 64'd0);
        chk("mid_rst_r_id", 64'(r_id_o), 64'd0);
        idle();
        m_reset();
        #1 chk("mid_rst_idle", 64'({ar_valid_o, ar_ready_o, r_valid_o, r_ready_o, ar_id_o}),
               64'd0);
        @(negedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1;

        // Randomized traffic
        last_ar_hs = 0;
        for (int c = 0; c < 600; c++) begin
            int k;
            if (ar_valid && !last_ar_hs) begin
                ar_ready = ($urandom_range(0, 2) != 0);
            end else if ($urandom_range(0, 9) < 6) begin
                set_ar(7'(32'h10 + $urandom_range(0, 5)), $urandom_range(0, 2) != 0);
            end else begin
                ar_valid = 0;
                ar_ready = 1'($urandom);
            end
            k = $urandom_range(0, NE - 1);
            if (m_vld[k] && $urandom_range(0, 1) == 1) begin
                set_r(6'(k), $urandom_range(0, 1) == 1);
                r_ready = ($urandom_range(0, 3) != 0);
            end else begin
                r_valid = 0; r_last = 0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
